// File: rtl/fifo_uart_tx.sv
// Drains a registered-output FIFO and serializes each byte as a UART frame (start, data LSB first, stop).
// Define FIFO_UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module fifo_uart_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd_en,
    output logic                  tx,
    output logic                  busy,
    output logic                  byte_done
);

    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_WIDTH-1:0] BIT_LAST = CNT_WIDTH'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        START,
        DATA,
`ifdef FIFO_UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [CNT_WIDTH-1:0]    bit_cnt;
    logic [IDX_W-1:0]        bit_idx;
    logic [DATA_WIDTH-1:0]   shift_reg;
    logic                    bit_end;
    logic                    timed;
`ifdef FIFO_UART_TX_PARITY_EN
    logic                    parity_bit;
`endif

    assign bit_end = (bit_cnt == BIT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        timed     = 1'b0;
        case (state)
            IDLE: begin
                if (enable && !fifo_empty) begin
                    state_nxt = FETCH;
                end
            end
            FETCH: state_nxt = LOAD;
            LOAD:  state_nxt = START;
            START: begin
                timed = 1'b1;
                if (bit_end) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                timed = 1'b1;
                if (bit_end && (bit_idx == IDX_LAST)) begin
`ifdef FIFO_UART_TX_PARITY_EN
                    state_nxt = PARITY;
`else
                    state_nxt = STOP;
`endif
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            PARITY: begin
                timed = 1'b1;
                if (bit_end) begin
                    state_nxt = STOP;
                end
            end
`endif
            STOP: begin
                timed = 1'b1;
                if (bit_end) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Counter restarts on every state change and at each DATA bit boundary, so bit periods never drift.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt   <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            if (!timed || bit_end || (state_nxt != state)) begin
                bit_cnt <= '0;
            end else begin
                bit_cnt <= bit_cnt + CNT_WIDTH'(1);
            end

            if (state == LOAD) begin
                shift_reg <= fifo_data;
                bit_idx   <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
                parity_bit <= ^fifo_data;
`endif
            end else if ((state == DATA) && bit_end) begin
                shift_reg <= shift_reg >> 1;
                bit_idx   <= bit_idx + IDX_W'(1);
            end
        end
    end

    always_comb begin
        tx         = 1'b1;
        fifo_rd_en = (state == FETCH);
        busy       = (state != IDLE);
        byte_done  = (state == STOP) && bit_end;
        case (state)
            START: tx = 1'b0;
            DATA:  tx = shift_reg[0];
`ifdef FIFO_UART_TX_PARITY_EN
            PARITY: tx = parity_bit;
`endif
            default: tx = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboard bench for fifo_uart_tx: a small FIFO model feeds bytes, a line monitor decodes tx frames.
// Honours FIFO_UART_TX_PARITY_EN the same way as the design.
module tb_fifo_uart_tx;

    localparam int DW  = 8;
    localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int NBITS = DW + 3;
`else
    localparam int NBITS = DW + 2;
`endif
    localparam int FRAME = NBITS * CPB;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          fifo_empty;
    logic [DW-1:0] fifo_data = '0;
    logic          fifo_rd_en;
    logic          tx;
    logic          busy;
    logic          byte_done;

    fifo_uart_tx #(
        .DATA_WIDTH  (DW),
        .CLKS_PER_BIT(CPB),
        .CNT_WIDTH   (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .tx         (tx),
        .busy       (busy),
        .byte_done  (byte_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // FIFO model with registered read data
    logic [DW-1:0] fifo_mem [0:15];
    int unsigned   wr_ptr = 0;
    int unsigned   rd_ptr = 0;
    int            empty_reads = 0;
    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            if (wr_ptr == rd_ptr) begin
                empty_reads <= empty_reads + 1;
            end else begin
                fifo_data <= fifo_mem[rd_ptr % 16];
                rd_ptr    <= rd_ptr + 1;
            end
        end
    end

    logic [DW-1:0] exp_q [$];

    task automatic push_byte(input logic [DW-1:0] b);
        fifo_mem[wr_ptr % 16] = b;
        wr_ptr = wr_ptr + 1;
        exp_q.push_back(b);
    endtask

    // Line monitor: samples tx once per cycle on the falling edge
    int             rd_cnt = 0;
    int             frames = 0;
    int             stray_bd = 0;
    int             mon_n = 0;
    int             hi_cnt = 0;
    int             last_gap = -1;
    int             bd_pos = -1;
    int             bd_in_frame = 0;
    logic           mon_active = 1'b0;
    logic [FRAME-1:0] smp;

    always @(negedge clk) begin
        if (fifo_rd_en) rd_cnt++;
        if (rst) begin
            mon_active = 1'b0;
            hi_cnt     = 0;
        end else begin
            if (!mon_active && (tx == 1'b0)) begin
                mon_active  = 1'b1;
                mon_n       = 0;
                bd_pos      = -1;
                bd_in_frame = 0;
                last_gap    = hi_cnt;
            end
            if (mon_active) begin
                smp[mon_n] = tx;
                if (byte_done) begin
                    bd_pos = mon_n;
                    bd_in_frame++;
                end
                mon_n++;
                if (mon_n == FRAME) begin
                    logic          width_ok;
                    logic [NBITS-1:0] bits;
                    logic [DW-1:0] got;
                    logic [DW-1:0] want;
                    width_ok = 1'b1;
                    for (int g = 0; g < NBITS; g++) begin
                        bits[g] = smp[g*CPB];
                        for (int k = 1; k < CPB; k++) begin
                            if (smp[g*CPB+k] != smp[g*CPB]) width_ok = 1'b0;
                        end
                    end
                    for (int i = 0; i < DW; i++) got[i] = bits[i+1];
                    check("bit_period", int'(width_ok), 1);
                    check("start_bit", int'(bits[0]), 0);
                    check("stop_bit", int'(bits[NBITS-1]), 1);
                    check("byte_done_count", bd_in_frame, 1);
                    check("byte_done_pos", bd_pos, FRAME - 1);
                    if (exp_q.size() == 0) begin
                        check("unexpected_frame", int'(got), -1);
                    end else begin
                        want = exp_q.pop_front();
                        check("data", int'(got), int'(want));
`ifdef FIFO_UART_TX_PARITY_EN
                        check("parity", int'(bits[DW+1]), int'(^want));
`endif
                    end
                    frames++;
                    mon_active = 1'b0;
                    hi_cnt     = 0;
                end
            end else begin
                if (byte_done) stray_bd++;
                if (tx) hi_cnt++;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_drain(input string tag, input int budget);
        logic done;
        done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if ((exp_q.size() == 0) && !busy && !mon_active) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) check(tag, 0, 1);
    endtask

    int rd_base;
    int fr_base;
    int flag_rd;
    int flag_busy;
    int flag_txlow;
    int flag_bd;

    initial begin
        rst    = 1'b1;
        enable = 1'b0;
        tick(3);
        check("rst_tx", int'(tx), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_byte_done", int'(byte_done), 0);
        check("rst_rd_en", int'(fifo_rd_en), 0);
        rst = 1'b0;

        // enable with an empty FIFO: nothing may move
        enable = 1'b1;
        flag_rd = 0; flag_busy = 0; flag_txlow = 0; flag_bd = 0;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (fifo_rd_en) flag_rd++;
            if (busy) flag_busy++;
            if (!tx) flag_txlow++;
            if (byte_done) flag_bd++;
        end
        check("empty_rd_en", flag_rd, 0);
        check("empty_busy", flag_busy, 0);
        check("empty_tx_low", flag_txlow, 0);
        check("empty_byte_done", flag_bd, 0);

        // single byte
        rd_base = rd_cnt; fr_base = frames;
        push_byte(8'hA5);
        wait_drain("a5_timeout", 200);
        check("a5_rd_pulses", rd_cnt - rd_base, 1);
        check("a5_frames", frames - fr_base, 1);

        // back-to-back bytes
        rd_base = rd_cnt; fr_base = frames;
        push_byte(8'h3C);
        push_byte(8'hFF);
        wait_drain("b2b_timeout", 400);
        check("b2b_rd_pulses", rd_cnt - rd_base, 2);
        check("b2b_frames", frames - fr_base, 2);
        check("b2b_gap", last_gap, 3);

        // enable dropped mid-frame
        rd_base = rd_cnt; fr_base = frames;
        push_byte(8'h55);
        push_byte(8'h66);
        flag_rd = 0;
        for (int i = 0; i < 200; i++) begin
            tick(1);
            if (mon_active && (mon_n >= 8)) begin
                flag_rd = 1;
                break;
            end
        end
        check("en_reach_data", flag_rd, 1);
        enable = 1'b0;
        tick(60);
        check("en_off_rd_pulses", rd_cnt - rd_base, 1);
        check("en_off_frames", frames - fr_base, 1);
        check("en_off_busy", int'(busy), 0);
        enable = 1'b1;
        wait_drain("en_on_timeout", 200);
        check("en_on_rd_pulses", rd_cnt - rd_base, 2);
        check("en_on_frames", frames - fr_base, 2);

        // reset in DATA bit 3
        push_byte(8'h96);
        flag_rd = 0;
        for (int i = 0; i < 200; i++) begin
            tick(1);
            if (mon_active && (mon_n >= 18)) begin
                flag_rd = 1;
                break;
            end
        end
        check("rst_reach_bit3", flag_rd, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_tx", int'(tx), 1);
        check("midrst_busy", int'(busy), 0);
        tick(2);
        rst = 1'b0;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        rd_base = rd_cnt;
        tick(20);
        check("postrst_rd_pulses", rd_cnt - rd_base, 0);
        check("postrst_busy", int'(busy), 0);
        push_byte(8'h81);
        wait_drain("postrst_timeout", 200);
        check("postrst_rd_after_push", rd_cnt - rd_base, 1);

`ifdef FIFO_UART_TX_PARITY_EN
        fr_base = frames;
        push_byte(8'hA5);
        push_byte(8'h07);
        wait_drain("par_timeout", 400);
        check("par_frames", frames - fr_base, 2);
`endif

        tick(5);
        check("empty_fifo_reads", empty_reads, 0);
        check("stray_byte_done", stray_bd, 0);
        check("leftover_expected", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
